// File: rtl/switch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_arbiter_pkg
// Description : Shared router configuration: port counts, output one-hot
//               encodings and the arbiter starvation age limit.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_arbiter_pkg;

    localparam int N         = 5;
    localparam int M         = 5;
    localparam int AGE_LIMIT = 15;

    // Output one-hot codes; index 0 (leftmost bit) is the local PE.
    localparam logic [0:M-1] c_out_pe = 5'b10000;
    localparam logic [0:M-1] c_out_n  = 5'b01000;
    localparam logic [0:M-1] c_out_e  = 5'b00100;
    localparam logic [0:M-1] c_out_s  = 5'b00010;
    localparam logic [0:M-1] c_out_w  = 5'b00001;

    typedef enum logic [2:0] {
        PORT_PE = 3'd0,
        PORT_N  = 3'd1,
        PORT_E  = 3'd2,
        PORT_S  = 3'd3,
        PORT_W  = 3'd4
    } port_e;

endpackage
`default_nettype wire

// File: rtl/switch_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational N-way cyclic priority pick starting at a
//               pointer; urgent requesters pre-empt non-urgent ones.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import switch_arbiter_pkg::*;
#(
    parameter int N     = switch_arbiter_pkg::N,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [0:N-1]       i_req,
    input  logic [0:N-1]       i_urgent,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [0:N-1]       o_winner
);

    logic             w_found;
    logic             w_any_urgent;
    logic [PTR_W-1:0] w_pos;

    always_comb begin
        o_winner     = '0;
        w_found      = 1'b0;
        w_pos        = '0;
        w_any_urgent = |(i_req & i_urgent);
        for (int k = 0; k < N; k++) begin
            w_pos = PTR_W'((int'(i_ptr) + k) % N);
            // When any requester is urgent, only urgent ones may win.
            if (!w_found && i_req[w_pos] && (!w_any_urgent || i_urgent[w_pos])) begin
                o_winner[w_pos] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : switch_arbiter
// Description : Per-output round-robin arbiter with starvation aging and
//               registered one-hot grants for the crossbar.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_arbiter
    import switch_arbiter_pkg::*;
#(
    parameter int N         = switch_arbiter_pkg::N,
    parameter int M         = switch_arbiter_pkg::M,
    parameter int AGE_LIMIT = switch_arbiter_pkg::AGE_LIMIT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [0:N-1][0:M-1] i_output_req,
    input  logic [0:M-1]        i_en,
    output logic [0:N-1][0:M-1] o_grant,
    output logic [0:M-1][0:N-1] o_sel,
    output logic [0:N-1]        o_input_ack,
    output logic [0:N-1]        o_req_err
);

    localparam int c_ptr_w = (N > 1) ? $clog2(N) : 1;
    localparam int c_age_w = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
    localparam logic [c_age_w-1:0] c_age_max = c_age_w'(AGE_LIMIT);

    logic [0:N-1][0:M-1]         w_req_norm;
    logic [0:N-1][0:M-1]         w_grant_next;
    logic [0:N-1]                w_multi;
    logic [0:N-1]                w_urgent;
    logic [0:N-1]                w_granted;
    logic [0:M-1][0:N-1]         w_col_req;
    logic [0:M-1][0:N-1]         w_win;
    logic [0:M-1][c_ptr_w-1:0]   w_ptr_next;
    logic [0:N-1][c_age_w-1:0]   w_age_next;

    logic [0:M-1][c_ptr_w-1:0]   r_ptr;
    logic [0:N-1][c_age_w-1:0]   r_age;
    logic [0:N-1][0:M-1]         r_grant;
    logic [0:M-1][0:N-1]         r_sel;
    logic [0:N-1]                r_ack;
    logic [0:N-1]                r_err;

    // Keep the lowest-index request bit; an input being acked sits out a cycle.
    always_comb begin
        w_req_norm = '0;
        w_multi    = '0;
        w_urgent   = '0;
        w_col_req  = '0;
        for (int n = 0; n < N; n++) begin
            for (int m = 0; m < M; m++) begin
                if (i_output_req[n][m] && (w_req_norm[n] == '0)) begin
                    w_req_norm[n][m] = 1'b1;
                end
            end
            w_multi[n]  = (w_req_norm[n] != i_output_req[n]);
            w_urgent[n] = (r_age[n] == c_age_max);
            for (int m = 0; m < M; m++) begin
                w_col_req[m][n] = w_req_norm[n][m] & ~r_ack[n] & i_en[m];
            end
        end
    end

    generate
        for (genvar m = 0; m < M; m++) begin : g_out
            rr_pick #(
                .N     (N),
                .PTR_W (c_ptr_w)
            ) u_pick (
                .i_req    (w_col_req[m]),
                .i_urgent (w_urgent),
                .i_ptr    (r_ptr[m]),
                .o_winner (w_win[m])
            );
        end
    endgenerate

    always_comb begin
        w_grant_next = '0;
        w_granted    = '0;
        w_ptr_next   = r_ptr;
        w_age_next   = r_age;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                if (w_win[m][n]) begin
                    w_grant_next[n][m] = 1'b1;
                    w_granted[n]       = 1'b1;
                    w_ptr_next[m]      = c_ptr_w'((n + 1) % N);
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            if (w_granted[n] || (w_req_norm[n] == '0)) begin
                w_age_next[n] = '0;
            end else if (r_age[n] != c_age_max) begin
                w_age_next[n] = r_age[n] + c_age_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_age   <= '0;
            r_grant <= '0;
            r_sel   <= '0;
            r_ack   <= '0;
            r_err   <= '0;
        end else begin
            r_ptr   <= w_ptr_next;
            r_age   <= w_age_next;
            r_grant <= w_grant_next;
            r_sel   <= w_win;
            r_ack   <= w_granted;
            r_err   <= w_multi;
        end
    end

    assign o_grant     = r_grant;
    assign o_sel       = r_sel;
    assign o_input_ack = r_ack;
    assign o_req_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_switch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_arbiter
// Description : Self-checking bench for switch_arbiter with a behavioural
//               arbitration model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_arbiter;

    localparam int N  = 5;
    localparam int M  = 5;
    localparam int AL = 3;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [0:N-1][0:M-1] req = '0;
    logic [0:M-1]        en = '1;
    logic [0:N-1][0:M-1] o_grant;
    logic [0:M-1][0:N-1] o_sel;
    logic [0:N-1]        o_input_ack;
    logic [0:N-1]        o_req_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int                  m_ptr [M];
    int                  m_age [N];
    logic [0:N-1][0:M-1] e_grant;
    logic [0:N-1]        e_ack;
    logic [0:N-1]        e_err;

    switch_arbiter #(.N(N), .M(M), .AGE_LIMIT(AL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_output_req (req),
        .i_en         (en),
        .o_grant      (o_grant),
        .o_sel        (o_sel),
        .o_input_ack  (o_input_ack),
        .o_req_err    (o_req_err)
    );

    always #5 clk = ~clk;

    function automatic logic [0:M-1][0:N-1] transpose(input logic [0:N-1][0:M-1] g);
        logic [0:M-1][0:N-1] t;
        t = '0;
        for (int n = 0; n < N; n++)
            for (int m = 0; m < M; m++)
                t[m][n] = g[n][m];
        return t;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < M; m++) m_ptr[m] = 0;
        for (int n = 0; n < N; n++) m_age[n] = 0;
        e_grant = '0;
        e_ack   = '0;
        e_err   = '0;
    endtask

    // One arbitration round from the rules: masked inputs sit out, urgent
    // requesters first in cyclic pointer order, then everyone else.
    task automatic model_step();
        int want [N];
        int best;
        int c;
        logic [0:N-1][0:M-1] g;
        g = '0;
        for (int n = 0; n < N; n++) begin
            want[n] = -1;
            for (int m = M - 1; m >= 0; m--)
                if (req[n][m]) want[n] = m;
            e_err[n] = ($countones(req[n]) > 1);
        end
        for (int m = 0; m < M; m++) begin
            if (en[m]) begin
                best = -1;
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr[m] + k) % N;
                    if (best < 0 && want[c] == m && !e_ack[c] && m_age[c] == AL) best = c;
                end
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr[m] + k) % N;
                    if (best < 0 && want[c] == m && !e_ack[c]) best = c;
                end
                if (best >= 0) begin
                    g[best][m] = 1'b1;
                    m_ptr[m]   = (best + 1) % N;
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            if (g[n] != '0 || want[n] < 0) m_age[n] = 0;
            else if (m_age[n] < AL) m_age[n] = m_age[n] + 1;
            e_ack[n] = (g[n] != '0);
        end
        e_grant = g;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = '0;
        en      = '1;
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (o_grant !== '0 || o_sel !== '0 || o_input_ack !== '0 || o_req_err !== '0) begin
            failures++;
            $display("FAIL reset_state grant=%h sel=%h ack=%b err=%b required all zero",
                     o_grant, o_sel, o_input_ack, o_req_err);
        end
    endtask

    task automatic test_single();
        req[2] = 5'b00100;
        tick();
        checks++;
        if (o_grant[2] !== 5'b00100 || o_sel[2] !== 5'b00100 || o_input_ack !== 5'b00100) begin
            failures++;
            $display("FAIL single grant2=%b sel2=%b ack=%b required 00100/00100/00100",
                     o_grant[2], o_sel[2], o_input_ack);
        end
        req = '0;
        tick();
        checks++;
        if (o_grant !== e_grant || o_input_ack !== e_ack) begin
            failures++;
            $display("FAIL single_release grant=%h ack=%b required %h/%b", o_grant, o_input_ack, e_grant, e_ack);
        end
    endtask

    task automatic test_contention();
        int order [3] = '{0, 1, 3};
        logic [0:N-1] oh;
        logic [0:N-1] prev_ack;
        apply_reset();
        req[0] = 5'b00001;
        req[1] = 5'b00001;
        req[3] = 5'b00001;
        prev_ack = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            oh = '0;
            oh[order[i % 3]] = 1'b1;
            checks++;
            if (o_input_ack !== oh || o_sel[4] !== oh || o_grant !== e_grant) begin
                failures++;
                $display("FAIL contention cyc=%0d ack=%b sel4=%b required %b (model grant %h)",
                         i, o_input_ack, o_sel[4], oh, e_grant);
            end
            checks++;
            if ((o_input_ack & prev_ack) !== '0) begin
                failures++;
                $display("FAIL contention_double cyc=%0d ack=%b prev=%b required no overlap",
                         i, o_input_ack, prev_ack);
            end
            prev_ack = o_input_ack;
        end
        req = '0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        en     = 5'b10111;
        req[4] = 5'b01000;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (o_input_ack !== '0 || o_grant !== e_grant) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d ack=%b required 00000", i, o_input_ack);
            end
        end
        en = '1;
        tick();
        checks++;
        if (o_grant[4] !== 5'b01000 || o_sel[1] !== 5'b00001 || o_input_ack !== 5'b00001) begin
            failures++;
            $display("FAIL backpressure_release grant4=%b sel1=%b ack=%b required 01000/00001/00001",
                     o_grant[4], o_sel[1], o_input_ack);
        end
        req = '0;
        tick();
    endtask

    task automatic test_starvation();
        apply_reset();
        en     = 5'b01111;
        req[4] = 5'b10000;
        for (int i = 0; i < AL; i++) begin
            tick();
            checks++;
            if (o_input_ack !== '0) begin
                failures++;
                $display("FAIL starvation_wait cyc=%0d ack=%b required 00000", i, o_input_ack);
            end
        end
        // Input 0 sits at the pointer but input 4 has aged to urgent.
        req[0] = 5'b10000;
        en     = '1;
        tick();
        checks++;
        if (o_grant[4] !== 5'b10000 || o_grant[0] !== 5'b00000 || o_sel[0] !== 5'b00001) begin
            failures++;
            $display("FAIL starvation_urgent grant4=%b grant0=%b sel0=%b required 10000/00000/00001",
                     o_grant[4], o_grant[0], o_sel[0]);
        end
        req[4] = '0;
        tick();
        checks++;
        if (o_grant !== e_grant || o_input_ack !== 5'b10000) begin
            failures++;
            $display("FAIL starvation_next grant=%h ack=%b required %h/10000", o_grant, o_input_ack, e_grant);
        end
        req = '0;
        tick();
    endtask

    task automatic test_multihot();
        apply_reset();
        req[1] = 5'b01010;
        tick();
        checks++;
        if (o_grant[1] !== 5'b01000 || o_req_err !== 5'b01000 || o_sel[3] !== 5'b00000) begin
            failures++;
            $display("FAIL multihot grant1=%b err=%b sel3=%b required 01000/01000/00000",
                     o_grant[1], o_req_err, o_sel[3]);
        end
        req = '0;
        tick();
        checks++;
        if (o_req_err !== 5'b00000) begin
            failures++;
            $display("FAIL multihot_clear err=%b required 00000", o_req_err);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        req[0] = 5'b10000;
        req[1] = 5'b01000;
        req[2] = 5'b00100;
        tick();
        checks++;
        if (o_input_ack !== 5'b11100) begin
            failures++;
            $display("FAIL midreset_setup ack=%b required 11100", o_input_ack);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (o_grant !== '0 || o_sel !== '0 || o_input_ack !== '0 || o_req_err !== '0) begin
            failures++;
            $display("FAIL midreset_async grant=%h sel=%h ack=%b err=%b required all zero",
                     o_grant, o_sel, o_input_ack, o_req_err);
        end
        model_clear();
        req    = '0;
        req[3] = 5'b00100;
        req[1] = 5'b00100;
        @(posedge clk);
        #1;
        checks++;
        if (o_input_ack !== '0) begin
            failures++;
            $display("FAIL midreset_held ack=%b required 00000", o_input_ack);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (o_grant[1] !== 5'b00100 || o_grant[3] !== 5'b00000 || o_input_ack !== 5'b01000) begin
            failures++;
            $display("FAIL midreset_first grant1=%b grant3=%b ack=%b required 00100/00000/01000",
                     o_grant[1], o_grant[3], o_input_ack);
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int n = 0; n < N; n++) begin
                if (e_ack[n] || req[n] == '0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        if ($urandom_range(0, 15) == 0) begin
                            req[n] = M'($urandom);
                        end else begin
                            req[n] = '0;
                            req[n][$urandom_range(0, M - 1)] = 1'b1;
                        end
                    end else begin
                        req[n] = '0;
                    end
                end
            end
            en = M'($urandom) | M'($urandom);
            tick();
            checks++;
            if (o_grant !== e_grant || o_sel !== transpose(e_grant) ||
                o_input_ack !== e_ack || o_req_err !== e_err) begin
                failures++;
                $display("FAIL random cyc=%0d grant=%h/%h ack=%b/%b err=%b/%b sel=%h (actual/required)",
                         cyc, o_grant, e_grant, o_input_ack, e_ack, o_req_err, e_err, o_sel);
            end
        end
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_starvation();
        test_multihot();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
